// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_pkg
// Description : Shared ALU opcode codes, MIPS op/funct constants and the
//               issue-entry record used by alu_issue and alu_issue_dec.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    localparam int ALU_OPT_WIDTH = 4;

    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_PASS_OPR1 = 4'd0;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_ADDU      = 4'd1;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SUBU      = 4'd2;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_AND       = 4'd3;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_OR        = 4'd4;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_XOR       = 4'd5;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_NOR       = 4'd6;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_LT        = 4'd7;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_LTU       = 4'd8;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SLL       = 4'd9;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SRL       = 4'd10;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SRA       = 4'd11;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SLL_IMM   = 4'd12;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SRL_IMM   = 4'd13;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SRA_IMM   = 4'd14;
    localparam logic [ALU_OPT_WIDTH-1:0] ALU_OPT_SETU      = 4'd15;

    localparam logic [5:0] MIPS_OP_SPECIAL = 6'h00;
    localparam logic [5:0] MIPS_OP_ADDIU   = 6'h09;
    localparam logic [5:0] MIPS_OP_SLTI    = 6'h0A;
    localparam logic [5:0] MIPS_OP_SLTIU   = 6'h0B;
    localparam logic [5:0] MIPS_OP_ANDI    = 6'h0C;
    localparam logic [5:0] MIPS_OP_ORI     = 6'h0D;
    localparam logic [5:0] MIPS_OP_XORI    = 6'h0E;
    localparam logic [5:0] MIPS_OP_LUI     = 6'h0F;

    localparam logic [5:0] MIPS_FUNCT_SLL  = 6'h00;
    localparam logic [5:0] MIPS_FUNCT_SRL  = 6'h02;
    localparam logic [5:0] MIPS_FUNCT_SRA  = 6'h03;
    localparam logic [5:0] MIPS_FUNCT_SLLV = 6'h04;
    localparam logic [5:0] MIPS_FUNCT_SRLV = 6'h06;
    localparam logic [5:0] MIPS_FUNCT_SRAV = 6'h07;
    localparam logic [5:0] MIPS_FUNCT_ADDU = 6'h21;
    localparam logic [5:0] MIPS_FUNCT_SUBU = 6'h23;
    localparam logic [5:0] MIPS_FUNCT_AND  = 6'h24;
    localparam logic [5:0] MIPS_FUNCT_OR   = 6'h25;
    localparam logic [5:0] MIPS_FUNCT_XOR  = 6'h26;
    localparam logic [5:0] MIPS_FUNCT_NOR  = 6'h27;
    localparam logic [5:0] MIPS_FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] MIPS_FUNCT_SLTU = 6'h2B;

    typedef struct packed {
        logic [ALU_OPT_WIDTH-1:0] opt;
        logic [31:0]              opr1;
        logic [31:0]              opr2;
        logic [31:0]              sa_imm;
        logic                     illegal;
    } alu_entry_t;

    localparam alu_entry_t ALU_ENTRY_RESET = '{
        opt:     ALU_OPT_PASS_OPR1,
        opr1:    32'd0,
        opr2:    32'd0,
        sa_imm:  32'd0,
        illegal: 1'b0
    };

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_dec
// Description : Combinational MIPS-word decoder producing ALU opcode/operands.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_dec
    import alu_issue_pkg::*;
(
    input  logic [31:0]              instr,
    input  logic [31:0]              rs_val,
    input  logic [31:0]              rt_val,
    output logic [ALU_OPT_WIDTH-1:0] opt,
    output logic [31:0]              opr1,
    output logic [31:0]              opr2,
    output logic [31:0]              sa_imm,
    output logic                     illegal
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic        w_unused_fields;

    assign w_op            = instr[31:26];
    assign w_funct         = instr[5:0];
    assign w_imm           = instr[15:0];
    // Register-specifier fields are resolved upstream into rs_val/rt_val.
    assign w_unused_fields = ^instr[25:16];

    always_comb begin
        opt     = ALU_OPT_PASS_OPR1;
        opr1    = rs_val;
        opr2    = rt_val;
        sa_imm  = {27'd0, instr[10:6]};
        illegal = 1'b0;
        case (w_op)
            MIPS_OP_SPECIAL: begin
                case (w_funct)
                    MIPS_FUNCT_SLL:  opt = ALU_OPT_SLL_IMM;
                    MIPS_FUNCT_SRL:  opt = ALU_OPT_SRL_IMM;
                    MIPS_FUNCT_SRA:  opt = ALU_OPT_SRA_IMM;
                    MIPS_FUNCT_SLLV: opt = ALU_OPT_SLL;
                    MIPS_FUNCT_SRLV: opt = ALU_OPT_SRL;
                    MIPS_FUNCT_SRAV: opt = ALU_OPT_SRA;
                    MIPS_FUNCT_ADDU: opt = ALU_OPT_ADDU;
                    MIPS_FUNCT_SUBU: opt = ALU_OPT_SUBU;
                    MIPS_FUNCT_AND:  opt = ALU_OPT_AND;
                    MIPS_FUNCT_OR:   opt = ALU_OPT_OR;
                    MIPS_FUNCT_XOR:  opt = ALU_OPT_XOR;
                    MIPS_FUNCT_NOR:  opt = ALU_OPT_NOR;
                    MIPS_FUNCT_SLT:  opt = ALU_OPT_LT;
                    MIPS_FUNCT_SLTU: opt = ALU_OPT_LTU;
                    default:         illegal = 1'b1;
                endcase
            end
            MIPS_OP_ADDIU: begin opt = ALU_OPT_ADDU; opr2 = sext16(w_imm); end
            MIPS_OP_SLTI:  begin opt = ALU_OPT_LT;   opr2 = sext16(w_imm); end
            MIPS_OP_SLTIU: begin opt = ALU_OPT_LTU;  opr2 = sext16(w_imm); end
            MIPS_OP_ANDI:  begin opt = ALU_OPT_AND;  opr2 = zext16(w_imm); end
            MIPS_OP_ORI:   begin opt = ALU_OPT_OR;   opr2 = zext16(w_imm); end
            MIPS_OP_XORI:  begin opt = ALU_OPT_XOR;  opr2 = zext16(w_imm); end
            MIPS_OP_LUI:   begin opt = ALU_OPT_SETU; opr2 = {w_imm, 16'h0000}; end
            default:       illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Registered ALU issue stage with valid/ready handshakes.
//               Define ALU_ISSUE_SKID_EN to add a one-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [31:0]              rs_val,
    input  logic [31:0]              rt_val,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_opr1,
    output logic [31:0]              out_opr2,
    output logic [31:0]              out_sa_imm,
    output logic [ALU_OPT_WIDTH-1:0] out_opt,
    output logic                     out_illegal
);

    logic [ALU_OPT_WIDTH-1:0] w_dec_opt;
    logic [31:0]              w_dec_opr1;
    logic [31:0]              w_dec_opr2;
    logic [31:0]              w_dec_sa_imm;
    logic                     w_dec_illegal;
    alu_entry_t               w_dec;
    alu_entry_t               r_out;
    logic                     r_out_valid;
    logic                     w_accept;
    logic                     w_drain;

    alu_issue_dec u_dec (
        .instr   (instr),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .opt     (w_dec_opt),
        .opr1    (w_dec_opr1),
        .opr2    (w_dec_opr2),
        .sa_imm  (w_dec_sa_imm),
        .illegal (w_dec_illegal)
    );

    assign w_dec    = '{opt: w_dec_opt, opr1: w_dec_opr1, opr2: w_dec_opr2,
                        sa_imm: w_dec_sa_imm, illegal: w_dec_illegal};
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_out_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
    alu_entry_t r_skid;
    logic       r_skid_valid;
    logic       r_in_ready;

    assign in_ready = r_in_ready;

    // in_ready is registered, so it tracks skid occupancy as of the last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out        <= ALU_ENTRY_RESET;
            r_skid_valid <= 1'b0;
            r_skid       <= ALU_ENTRY_RESET;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (r_skid_valid && (w_drain || !r_out_valid)) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_accept && (w_drain || !r_out_valid)) begin
            r_out        <= w_dec;
            r_out_valid  <= 1'b1;
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= ALU_ENTRY_RESET;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_dec;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    assign out_valid   = r_out_valid;
    assign out_opt     = r_out.opt;
    assign out_opr1    = r_out.opr1;
    assign out_opr2    = r_out.opr2;
    assign out_sa_imm  = r_out.sa_imm;
    assign out_illegal = r_out.illegal;

endmodule
`default_nettype wire
